// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [7:0]            wdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic                  uart_txd
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(STOP_BITS * DIV);

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;

  localparam cnt_t BIT_END  = cnt_t'(DIV - 1);
  localparam cnt_t STOP_END = cnt_t'(STOP_BITS * DIV - 1);
  localparam lvl_t LVL_FULL = lvl_t'(2 ** DEPTH_LOG2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [7:0] mem_q [2**DEPTH_LOG2];

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  ptr_t       wptr_q, wptr_d;
  ptr_t       rptr_q, rptr_d;
  lvl_t       count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       ovf_q, ovf_d;
  logic       push, pop;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  // A full FIFO drops the push even when a pop frees a slot this cycle.
  assign push = wr & ~full_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == STOP_END) begin
          cnt_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (pop) begin
      shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rptr_q];
`endif
    end
    // Line level follows the next state so it lines up with the state flop.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + ptr_t'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + ptr_t'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + lvl_t'(1);
      2'b01:   count_d = count_q - lvl_t'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == LVL_FULL);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | (wr & full_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: timing, back-to-back, overflow, reset.
// A line receiver decodes every frame into rxq for byte checks.
module tb_uart_tx_fifo;

  localparam int DIV = 208;
  localparam int H   = DIV / 2;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB    = 10 + P;
  localparam int FRAME = NB * DIV;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic [7:0] wdata;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       busy;
  logic       uart_txd;

  int total = 0;
  int bad   = 0;

  logic [7:0] rxq [$];

  uart_tx_fifo dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .wdata    (wdata),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .uart_txd (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line receiver, sampling mid-bit on the falling clock edge.
  logic       rx_on;
  int         rx_cnt;
  logic [7:0] rx_sh;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (uart_txd === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == H) begin
        chk("rx_start", uart_txd, 0);
      end else if (rx_cnt > H && (rx_cnt - H) % DIV == 0) begin
        int k;
        k = (rx_cnt - H) / DIV;
        if (k <= 8) begin
          rx_sh[k-1] = uart_txd;
        end else if (k == 9 + P) begin
          chk("rx_stop", uart_txd, 1);
          rxq.push_back(rx_sh);
          rx_on = 1'b0;
        end else begin
          chk("rx_parity", uart_txd, ^rx_sh);
        end
      end
    end
  end

  task automatic push1(input logic [7:0] b);
    wr    = 1'b1;
    wdata = b;
    wait_cyc(1);
    wr    = 1'b0;
  endtask

  // Push one byte while idle and check the line bit by bit.
  task automatic frame_chk(input logic [7:0] b);
    logic [10:0] seq;
    seq       = '1;
    seq[0]    = 1'b0;
    seq[8:1]  = b;
`ifdef UART_TX_PARITY_EN
    seq[9]    = ^b;
`endif
    push1(b);
    chk("push_empty", empty, 0);
    chk("push_txd", uart_txd, 1);
    wait_cyc(1);
    chk("fall_txd", uart_txd, 0);
    chk("fall_busy", busy, 1);
    wait_cyc(H);
    chk("bit0", uart_txd, seq[0]);
    for (int i = 1; i < NB; i++) begin
      wait_cyc(DIV);
      chk($sformatf("bit%0d", i), uart_txd, seq[i]);
    end
    wait_cyc(H - 1);
    chk("busy_end", busy, 1);
    wait_cyc(1);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    int base;
    int maxlvl;
    int gap;
    int n;
    logic [7:0] b2b [3];
    b2b[0] = 8'h55;
    b2b[1] = 8'hAA;
    b2b[2] = 8'h0F;

    reset_n = 1'b0;
    wr      = 1'b0;
    wdata   = 8'h00;
    wait_cyc(3);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      wait_cyc(1);
      chk("idle", {uart_txd, empty, busy, level}, {1'b1, 1'b1, 1'b0, 5'd0});
    end

    base = rxq.size();
    frame_chk(8'h41);
    chk("rx41_n", rxq.size() - base, 1);
    chk("rx41", rxq[base], 8'h41);

    base   = rxq.size();
    maxlvl = 0;
    for (int i = 0; i < 3; i++) begin
      wr    = 1'b1;
      wdata = b2b[i];
      wait_cyc(1);
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    wr = 1'b0;
    chk("b2b_peak", maxlvl, 2);
    gap = 0;
    for (int i = 0; i < 3 * FRAME - 2; i++) begin
      wait_cyc(1);
      if (!busy) gap++;
    end
    chk("b2b_gap", gap, 0);
    wait_cyc(1);
    chk("b2b_idle", busy, 0);
    chk("b2b_empty", empty, 1);
    chk("b2b_n", rxq.size() - base, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_rx%0d", i), rxq[base+i], b2b[i]);

    base = rxq.size();
    push1(8'h11);
    wait_cyc(4);
    chk("ovf_busy", busy, 1);
    wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wdata = 8'h20 + 8'(i);
      wait_cyc(1);
      if (i == 15) begin
        chk("ovf_full16", full, 1);
        chk("ovf_lvl16", level, 16);
        chk("ovf_pre", overflow, 0);
      end
    end
    wr = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_lvl", level, 16);
    wait_cyc(DIV);
    chk("ovf_sticky", overflow, 1);
    n = 0;
    while (busy && n < 20 * FRAME) begin
      wait_cyc(1);
      n++;
    end
    chk("ovf_drain", busy, 0);
    chk("ovf_sticky2", overflow, 1);
    chk("ovf_n", rxq.size() - base, 17);
    if (rxq.size() - base == 17) begin
      chk("ovf_rx0", rxq[base], 8'h11);
      for (int i = 1; i < 17; i++)
        chk($sformatf("ovf_rx%0d", i), rxq[base+i], 8'h1F + 8'(i));
    end

    base = rxq.size();
    push1(8'hA5);
    push1(8'h3C);
    wait_cyc(3 * DIV);
    chk("mid_lvl", level, 1);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_txd", uart_txd, 1);
    chk("abort_lvl", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_empty", empty, 1);
    chk("abort_ovf", overflow, 0);
    wait_cyc(2);
    reset_n = 1'b1;
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      wait_cyc(1);
      if (!uart_txd || busy) gap++;
    end
    chk("post_quiet", gap, 0);
    chk("post_rx_n", rxq.size() - base, 0);

`ifdef UART_TX_PARITY_EN
    base = rxq.size();
    frame_chk(8'h07);
    chk("par_rx", rxq[base], 8'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
